// File: rtl/rect_plotter.sv
// rect_plotter: fills a w x h rectangle one pixel per clock, clipping pixels past X_MAX/Y_MAX.
// Optional macro RECT_PLOTTER_CLEAR_EN adds a `clear` input that fills the whole screen.
module rect_plotter #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int X_MAX    = 159,
    parameter int Y_MAX    = 119
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [X_W-1:0]      w,
    input  logic [Y_W-1:0]      h,
    input  logic [COLOUR_W-1:0] fill_colour,
`ifdef RECT_PLOTTER_CLEAR_EN
    input  logic                clear,
`endif
    output logic                busy,
    output logic                done,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot
);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    localparam logic [X_W:0]   X_LIM  = (X_W+1)'(X_MAX);
    localparam logic [Y_W:0]   Y_LIM  = (Y_W+1)'(Y_MAX);
    localparam logic [X_W-1:0] X_ONE  = 1;
    localparam logic [Y_W-1:0] Y_ONE  = 1;
`ifdef RECT_PLOTTER_CLEAR_EN
    localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX);
`endif

    state_t state, state_n;
    logic [X_W-1:0]      x_base, x_base_n, last_cx, last_cx_n, cx, cx_n, x_n;
    logic [Y_W-1:0]      y_base, y_base_n, last_cy, last_cy_n, cy, cy_n, y_n;
    logic [COLOUR_W-1:0] col_r, col_n, colour_n;
    logic                plot_n, busy_n, done_n;
    logic [X_W-1:0]      sel_x0, sel_last_cx;
    logic [Y_W-1:0]      sel_y0, sel_last_cy;
    logic                sel_empty;
    logic [X_W:0]        px;
    logic [Y_W:0]        py;

    // Offsets run to last_cx/last_cy (w-1, h-1) so a full-width clear never needs w+1 bits.
    always_comb begin
        state_n   = state;
        x_base_n  = x_base;
        y_base_n  = y_base;
        last_cx_n = last_cx;
        last_cy_n = last_cy;
        col_n     = col_r;
        cx_n      = cx;
        cy_n      = cy;
        x_n       = x;
        y_n       = y;
        colour_n  = colour;
        plot_n    = 1'b0;
        busy_n    = 1'b0;
        done_n    = 1'b0;

        sel_x0      = x0;
        sel_y0      = y0;
        sel_last_cx = w - X_ONE;
        sel_last_cy = h - Y_ONE;
        sel_empty   = (w == '0) || (h == '0);
`ifdef RECT_PLOTTER_CLEAR_EN
        if (clear) begin
            sel_x0      = '0;
            sel_y0      = '0;
            sel_last_cx = X_LAST;
            sel_last_cy = Y_LAST;
            sel_empty   = 1'b0;
        end
`endif
        px = {1'b0, x_base} + {1'b0, cx};
        py = {1'b0, y_base} + {1'b0, cy};

        unique case (state)
            IDLE: begin
                if (start) begin
                    x_base_n  = sel_x0;
                    y_base_n  = sel_y0;
                    last_cx_n = sel_last_cx;
                    last_cy_n = sel_last_cy;
                    col_n     = fill_colour;
                    cx_n      = '0;
                    cy_n      = '0;
                    busy_n    = 1'b1;
                    if (sel_empty) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n  = DRAW;
                        px       = {1'b0, sel_x0};
                        py       = {1'b0, sel_y0};
                        x_n      = sel_x0;
                        y_n      = sel_y0;
                        colour_n = fill_colour;
                        plot_n   = (px <= X_LIM) && (py <= Y_LIM);
                    end
                end
            end
            DRAW: begin
                busy_n = 1'b1;
                if (cx == last_cx && cy == last_cy) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    if (cx == last_cx) begin
                        cx_n = '0;
                        cy_n = cy + Y_ONE;
                    end else begin
                        cx_n = cx + X_ONE;
                    end
                    px       = {1'b0, x_base} + {1'b0, cx_n};
                    py       = {1'b0, y_base} + {1'b0, cy_n};
                    x_n      = px[X_W-1:0];
                    y_n      = py[Y_W-1:0];
                    colour_n = col_r;
                    plot_n   = (px <= X_LIM) && (py <= Y_LIM);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= IDLE;
            x_base  <= '0;
            y_base  <= '0;
            last_cx <= '0;
            last_cy <= '0;
            col_r   <= '0;
            cx      <= '0;
            cy      <= '0;
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            plot    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            x_base  <= x_base_n;
            y_base  <= y_base_n;
            last_cx <= last_cx_n;
            last_cy <= last_cy_n;
            col_r   <= col_n;
            cx      <= cx_n;
            cy      <= cy_n;
            x       <= x_n;
            y       <= y_n;
            colour  <= colour_n;
            plot    <= plot_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_rect_plotter.sv
// Scoreboard bench for rect_plotter: stimulus pushes expected plot/done events with their cycle,
// a forked monitor pops and compares them whenever the DUT raises plot or done.
`timescale 1ns/1ps
module tb_rect_plotter;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [7:0] w;
    logic [6:0] h;
    logic [2:0] fill_colour;
    logic       busy, done, plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
`ifdef RECT_PLOTTER_CLEAR_EN
    logic       clear;
    logic       c_start, c_clear, c_busy, c_done, c_plot;
    logic [7:0] c_x;
    logic [6:0] c_y;
    logic [2:0] c_colour;
`endif

    typedef struct packed {
        logic        is_done;
        logic        pl;
        logic        bz;
        logic [7:0]  px;
        logic [6:0]  py;
        logic [2:0]  col;
        logic [31:0] cyc;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned cycle = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cycle <= cycle + 1;

    rect_plotter #(.X_W(8), .Y_W(7), .COLOUR_W(3), .X_MAX(159), .Y_MAX(119)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
        .x0(x0), .y0(y0), .w(w), .h(h), .fill_colour(fill_colour),
`ifdef RECT_PLOTTER_CLEAR_EN
        .clear(clear),
`endif
        .busy(busy), .done(done), .x(x), .y(y), .colour(colour), .plot(plot)
    );

`ifdef RECT_PLOTTER_CLEAR_EN
    ev_t clr_q[$];

    rect_plotter #(.X_W(8), .Y_W(7), .COLOUR_W(3), .X_MAX(3), .Y_MAX(1)) u_clr (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(c_start),
        .x0(x0), .y0(y0), .w(w), .h(h), .fill_colour(fill_colour), .clear(c_clear),
        .busy(c_busy), .done(c_done), .x(c_x), .y(c_y), .colour(c_colour), .plot(c_plot)
    );
`endif

    task automatic tick();
        @(posedge CLOCK_50);
        #2;
    endtask

    task automatic checkOutput(input string name, input int actual, input int required);
        n_checks++;
        if (actual != required) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic compareEvent(input string name, input ev_t act, input ev_t req, input bit have_req);
        n_checks++;
        if (!have_req) begin
            n_fail++;
            $display("[TB] FAIL %s unexpected output: actual done=%0b plot=%0b x=%0d y=%0d cycle=%0d, required no output",
                     name, act.is_done, act.pl, act.px, act.py, act.cyc);
        end else if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s event: actual done=%0b plot=%0b busy=%0b x=%0d y=%0d colour=%0d cycle=%0d, required done=%0b plot=%0b busy=%0b x=%0d y=%0d colour=%0d cycle=%0d",
                     name, act.is_done, act.pl, act.bz, act.px, act.py, act.col, act.cyc,
                     req.is_done, req.pl, req.bz, req.px, req.py, req.col, req.cyc);
        end
    endtask

    task automatic monitor();
        ev_t act;
        ev_t req;
        forever begin
            @(negedge CLOCK_50);
            if (plot || done) begin
                act.is_done = done;
                act.pl      = plot;
                act.bz      = busy;
                act.px      = done ? 8'd0 : x;
                act.py      = done ? 7'd0 : y;
                act.col     = done ? 3'd0 : colour;
                act.cyc     = cycle;
                req         = '0;
                if (exp_q.size() != 0) begin
                    req = exp_q.pop_front();
                    compareEvent("main", act, req, 1'b1);
                end else begin
                    compareEvent("main", act, req, 1'b0);
                end
            end
        end
    endtask

`ifdef RECT_PLOTTER_CLEAR_EN
    task automatic monitorClr();
        ev_t act;
        ev_t req;
        forever begin
            @(negedge CLOCK_50);
            if (c_plot || c_done) begin
                act.is_done = c_done;
                act.pl      = c_plot;
                act.bz      = c_busy;
                act.px      = c_done ? 8'd0 : c_x;
                act.py      = c_done ? 7'd0 : c_y;
                act.col     = c_done ? 3'd0 : c_colour;
                act.cyc     = cycle;
                req         = '0;
                if (clr_q.size() != 0) begin
                    req = clr_q.pop_front();
                    compareEvent("clear", act, req, 1'b1);
                end else begin
                    compareEvent("clear", act, req, 1'b0);
                end
            end
        end
    endtask
`endif

    function automatic ev_t pixelEv(input int px, input int py, input logic [2:0] col, input int cyc);
        ev_t e;
        e.is_done = 1'b0;
        e.pl      = 1'b1;
        e.bz      = 1'b1;
        e.px      = px[7:0];
        e.py      = py[6:0];
        e.col     = col;
        e.cyc     = cyc;
        return e;
    endfunction

    function automatic ev_t doneEv(input int cyc);
        ev_t e;
        e         = '0;
        e.is_done = 1'b1;
        e.bz      = 1'b1;
        e.cyc     = cyc;
        return e;
    endfunction

    // limit < 0 expects the whole rectangle plus done; otherwise only the first `limit` raster slots.
    task automatic applyStimulus(input logic [7:0] ax0, input logic [6:0] ay0, input logic [7:0] aw,
                                 input logic [6:0] ah, input logic [2:0] acol, input int limit);
        int n;
        int idx;
        int px;
        int py;
        x0 = ax0; y0 = ay0; w = aw; h = ah; fill_colour = acol;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = int'(cycle);
        idx = 0;
        for (int cy = 0; cy < int'(ah); cy++) begin
            for (int cx = 0; cx < int'(aw); cx++) begin
                px = int'(ax0) + cx;
                py = int'(ay0) + cy;
                if ((limit < 0 || idx < limit) && px <= 159 && py <= 119)
                    exp_q.push_back(pixelEv(px, py, acol, n + idx));
                idx++;
            end
        end
        if (limit < 0)
            exp_q.push_back(doneEv(n + int'(aw) * int'(ah)));
    endtask

    task automatic waitDone(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            tick();
            k++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s timeout: actual %0d events pending, required 0", name, exp_q.size());
            exp_q.delete();
        end else begin
            checkOutput({name, "_busy_after"}, int'(busy), 0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        x0 = '0; y0 = '0; w = '0; h = '0; fill_colour = '0;
`ifdef RECT_PLOTTER_CLEAR_EN
        clear = 1'b0; c_start = 1'b0; c_clear = 1'b0;
`endif
        fork
            monitor();
`ifdef RECT_PLOTTER_CLEAR_EN
            monitorClr();
`endif
        join_none

        repeat (3) tick();
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_plot", int'(plot), 0);
        checkOutput("reset_x", int'(x), 0);
        checkOutput("reset_y", int'(y), 0);
        checkOutput("reset_colour", int'(colour), 0);
        reset = 1'b0;
        tick();

        $display("[TB] basic fill");
        applyStimulus(8'd10, 7'd5, 8'd2, 7'd2, 3'd5, -1);
        waitDone("basic");

        $display("[TB] empty rectangle");
        applyStimulus(8'd20, 7'd20, 8'd0, 7'd3, 3'd4, -1);
        checkOutput("empty_busy", int'(busy), 1);
        waitDone("empty");

        $display("[TB] clipping");
        applyStimulus(8'd158, 7'd119, 8'd4, 7'd2, 3'd6, -1);
        waitDone("clip");
        applyStimulus(8'd157, 7'd117, 8'd3, 7'd2, 3'd7, -1);
        waitDone("edge");
        applyStimulus(8'd200, 7'd10, 8'd1, 7'd1, 3'd1, -1);
        waitDone("offscreen_x");
        applyStimulus(8'd5, 7'd127, 8'd1, 7'd1, 3'd2, -1);
        waitDone("offscreen_y");

        $display("[TB] busy lockout");
        applyStimulus(8'd20, 7'd30, 8'd3, 7'd1, 3'd1, -1);
        x0 = 8'd0; y0 = 7'd0; w = 8'd5; h = 7'd5; fill_colour = 3'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        waitDone("lockout");
        repeat (4) tick();
        checkOutput("lockout_idle_busy", int'(busy), 0);

        $display("[TB] reset mid-draw");
        applyStimulus(8'd50, 7'd60, 8'd4, 7'd4, 3'd3, 2);
        tick();
        reset = 1'b1;
        tick();
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_plot", int'(plot), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_x", int'(x), 0);
        reset = 1'b0;
        checkOutput("rst_pending", exp_q.size(), 0);
        exp_q.delete();
        tick();
        applyStimulus(8'd7, 7'd8, 8'd1, 7'd1, 3'd6, -1);
        waitDone("after_reset");

`ifdef RECT_PLOTTER_CLEAR_EN
        $display("[TB] clear mode");
        begin
            int n;
            int k;
            x0 = 8'd5; y0 = 7'd5; w = 8'd0; h = 7'd0; fill_colour = 3'd2;
            c_clear = 1'b1; c_start = 1'b1;
            tick();
            c_start = 1'b0; c_clear = 1'b0;
            n = int'(cycle);
            for (int cy = 0; cy < 2; cy++)
                for (int cx = 0; cx < 4; cx++)
                    clr_q.push_back(pixelEv(cx, cy, 3'd2, n + cy * 4 + cx));
            clr_q.push_back(doneEv(n + 8));
            k = 0;
            while (clr_q.size() != 0 && k < 100) begin
                tick();
                k++;
            end
            if (clr_q.size() != 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL clear timeout: actual %0d events pending, required 0", clr_q.size());
            end else begin
                checkOutput("clear_busy_after", int'(c_busy), 0);
            end
        end
`endif

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
